// File: rtl/flow_ctrl_pkg.sv
// Shared definitions for the flow route sequencer: opcodes, FSM state codes,
// switch indices and the route/legality decode functions.
package flow_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_LOAD_MIX    = 2'd0,
        OP_MIX_TO_HEAT = 2'd1,
        OP_HEAT_TO_OUT = 2'd2,
        OP_RSVD        = 2'd3
    } op_e;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLOSE = 3'd1;
    localparam logic [2:0] ST_OPEN  = 3'd2;
    localparam logic [2:0] ST_PUMP  = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;
    localparam logic [2:0] ST_FIN   = 3'd5;

    // Position of each physical switch within the 32-bit valve vector
    localparam int SW_S0 = 0;
    localparam int SW_S1 = 1;
    localparam int SW_S2 = 2;
    localparam int SW_S4 = 3;
    localparam int SW_S5 = 4;
    localparam int SW_S7 = 5;
    localparam int SW_S8 = 6;
    localparam int SW_S9 = 7;

    function automatic logic [31:0] port_bit(input int sw, input int port);
        return 32'd1 << (sw * 4 + port);
    endfunction

    function automatic logic [31:0] route_mask(input op_e op, input logic [1:0] a, input logic [1:0] b);
        logic [31:0] m;
        m = 32'd0;
        case (op)
            OP_LOAD_MIX: begin
                m = port_bit(SW_S0, a[0] ? 1 : 2) | port_bit(SW_S0, 3)
                  | port_bit(SW_S1, 2) | port_bit(SW_S1, b[1] ? 0 : 1);
                case (b)
                    2'd0:    m = m | port_bit(SW_S2, 2) | port_bit(SW_S2, 3);
                    2'd1:    m = m | port_bit(SW_S2, 2) | port_bit(SW_S2, 0);
                    2'd2:    m = m | port_bit(SW_S4, 1) | port_bit(SW_S4, 2);
                    default: m = m | port_bit(SW_S4, 1) | port_bit(SW_S4, 3);
                endcase
            end
            OP_MIX_TO_HEAT: begin
                if (!a[1])
                    m = port_bit(SW_S2, a[0] ? 0 : 3) | port_bit(SW_S2, 1)
                      | port_bit(SW_S5, 1) | port_bit(SW_S5, b[0] ? 0 : 3);
                else
                    m = port_bit(SW_S4, a[0] ? 3 : 2) | port_bit(SW_S4, 0)
                      | port_bit(SW_S7, 2) | port_bit(SW_S7, b[0] ? 0 : 3);
            end
            OP_HEAT_TO_OUT: begin
                if (!a[1])
                    m = port_bit(SW_S5, a[0] ? 0 : 3) | port_bit(SW_S5, 2)
                      | port_bit(SW_S8, 3) | port_bit(SW_S8, 0);
                else
                    m = port_bit(SW_S7, a[0] ? 0 : 3) | port_bit(SW_S7, 1)
                      | port_bit(SW_S8, 2) | port_bit(SW_S8, 0);
                m = m | port_bit(SW_S9, 1) | port_bit(SW_S9, b[0] ? 0 : 3) | port_bit(SW_S9, 2);
            end
            default: m = 32'd0;
        endcase
        return m;
    endfunction

    // Mixers 0/1 only reach heaters 0/1, mixers 2/3 only heaters 2/3
    function automatic logic legal(input op_e op, input logic [1:0] a, input logic [1:0] b);
        case (op)
            OP_LOAD_MIX:    return 1'b1;
            OP_MIX_TO_HEAT: return a[1] == b[1];
            OP_HEAT_TO_OUT: return !b[1];
            default:        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/flow_route_decode.sv
// Combinational command decode: valve route mask and legality of a routing command.
module flow_route_decode
    import flow_ctrl_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [1:0]  a,
    input  logic [1:0]  b,
    output logic [31:0] mask,
    output logic        ok
);

    assign mask = route_mask(op_e'(op), a, b);
    assign ok   = legal(op_e'(op), a, b);

endmodule

// File: rtl/flow_route_sequencer.sv
// Routing command sequencer: close valves, open route, pump for a dwell time,
// hold, close, then report done (or err on abort / illegal command).
module flow_route_sequencer
    import flow_ctrl_pkg::*;
#(
    parameter int SETTLE_CYC = 16,
    parameter int DWELL_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [1:0]         cmd_a,
    input  logic [1:0]         cmd_b,
    input  logic [DWELL_W-1:0] cmd_dwell,
    input  logic               abort_i,
    output logic [31:0]        valve_o,
    output logic               pump_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
);

    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYC - 1);

    logic [2:0]         state_reg,   state_next;
    logic [SET_W-1:0]   settle_reg,  settle_next;
    logic [DWELL_W-1:0] pump_reg,    pump_next;
    logic [DWELL_W-1:0] dwell_reg,   dwell_next;
    logic [31:0]        route_reg,   route_next;
    logic               aborted_reg, aborted_next;
    logic               illegal_reg, illegal_next;

    logic [31:0] dec_mask;
    logic        dec_ok;

    flow_route_decode u_decode (
        .op   (cmd_op),
        .a    (cmd_a),
        .b    (cmd_b),
        .mask (dec_mask),
        .ok   (dec_ok)
    );

    always_comb begin
        state_next   = state_reg;
        settle_next  = settle_reg;
        pump_next    = pump_reg;
        dwell_next   = dwell_reg;
        route_next   = route_reg;
        aborted_next = aborted_reg;
        illegal_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (dec_ok) begin
                        state_next   = ST_CLOSE;
                        settle_next  = SETTLE_LOAD;
                        route_next   = dec_mask;
                        dwell_next   = cmd_dwell;
                        aborted_next = 1'b0;
                    end else begin
                        illegal_next = 1'b1;
                    end
                end
            end
            ST_CLOSE: begin
                if (abort_i) begin
                    state_next   = ST_FIN;
                    aborted_next = 1'b1;
                end else if (settle_reg == '0) begin
                    state_next  = ST_OPEN;
                    settle_next = SETTLE_LOAD;
                end else begin
                    settle_next = settle_reg - 1'b1;
                end
            end
            ST_OPEN: begin
                if (abort_i) begin
                    state_next   = ST_FIN;
                    aborted_next = 1'b1;
                end else if (settle_reg == '0) begin
                    if (dwell_reg == '0) begin
                        state_next  = ST_HOLD;
                        settle_next = SETTLE_LOAD;
                    end else begin
                        state_next = ST_PUMP;
                        pump_next  = dwell_reg - 1'b1;
                    end
                end else begin
                    settle_next = settle_reg - 1'b1;
                end
            end
            ST_PUMP: begin
                if (abort_i || pump_reg == '0) begin
                    state_next   = ST_HOLD;
                    settle_next  = SETTLE_LOAD;
                    aborted_next = aborted_reg | abort_i;
                end else begin
                    pump_next = pump_reg - 1'b1;
                end
            end
            ST_HOLD: begin
                if (settle_reg == '0)
                    state_next = ST_FIN;
                else
                    settle_next = settle_reg - 1'b1;
            end
            ST_FIN: begin
                state_next   = ST_IDLE;
                aborted_next = 1'b0;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            settle_reg  <= '0;
            pump_reg    <= '0;
            dwell_reg   <= '0;
            route_reg   <= '0;
            aborted_reg <= 1'b0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            settle_reg  <= settle_next;
            pump_reg    <= pump_next;
            dwell_reg   <= dwell_next;
            route_reg   <= route_next;
            aborted_reg <= aborted_next;
            illegal_reg <= illegal_next;
        end
    end

    // All outputs decode registered state, so a reset clears them on the next edge
    assign cmd_ready = (state_reg == ST_IDLE);
    assign busy_o    = (state_reg != ST_IDLE);
    assign pump_o    = (state_reg == ST_PUMP);
    assign valve_o   = (state_reg == ST_OPEN || state_reg == ST_PUMP || state_reg == ST_HOLD)
                       ? route_reg : 32'd0;
    assign done_o    = (state_reg == ST_FIN) && !aborted_reg;
    assign err_o     = ((state_reg == ST_FIN) && aborted_reg) || illegal_reg;

endmodule
